// File: rtl/wt_mem_arbiter.sv
// wt_mem_arbiter: merges NumPorts cache request channels onto one memory port,
// tags memory IDs with the source port, routes returns by that tag and fans
// memory invalidations out to every port.
// Build option: define WT_MEM_ARB_FIXED_PRIO_EN for fixed lowest-index priority
// (no round-robin pointer); default build is round-robin.

// Per-port outstanding request counter.
module wt_mem_arb_port_cnt #(
  parameter int CntW           = 3,
  parameter int MaxOutstanding = 4
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            inc_i,
  input  logic            dec_i,
  output logic [CntW-1:0] cnt_o,
  output logic            avail_o
);
  logic [CntW-1:0] cnt_q, cnt_d;

  // Simultaneous increment and decrement cancel out.
  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && !dec_i)      cnt_d = cnt_q + 1'b1;
    else if (dec_i && !inc_i) cnt_d = cnt_q - 1'b1;
  end

  // Counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign cnt_o   = cnt_q;
  assign avail_o = (cnt_q < CntW'(MaxOutstanding));
endmodule

module wt_mem_arbiter #(
  parameter  int NumPorts       = 2,
  parameter  int AddrWidth      = 56,
  parameter  int DataWidth      = 64,
  parameter  int RtrnWidth      = 128,
  parameter  int TxIdWidth      = 2,
  parameter  int MaxOutstanding = 4,
  localparam int IdxW           = (NumPorts > 1) ? $clog2(NumPorts) : 1,
  localparam int MemIdW         = TxIdWidth + IdxW
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  // cache side
  input  logic [NumPorts-1:0]                 req_i,
  input  logic [NumPorts-1:0][AddrWidth-1:0]  req_addr_i,
  input  logic [NumPorts-1:0][DataWidth-1:0]  req_wdata_i,
  input  logic [NumPorts-1:0][2:0]            req_type_i,
  input  logic [NumPorts-1:0][TxIdWidth-1:0]  req_tid_i,
  output logic [NumPorts-1:0]                 ack_o,
  output logic [NumPorts-1:0]                 rtrn_vld_o,
  output logic [RtrnWidth-1:0]                rtrn_data_o,
  output logic [2:0]                          rtrn_type_o,
  output logic [TxIdWidth-1:0]                rtrn_tid_o,
  output logic [NumPorts-1:0]                 inv_req_o,
  output logic [AddrWidth-1:0]                inv_addr_o,
  input  logic [NumPorts-1:0]                 inv_ack_i,
  // memory side
  output logic                                mem_req_o,
  output logic [AddrWidth-1:0]                mem_addr_o,
  output logic [DataWidth-1:0]                mem_wdata_o,
  output logic [2:0]                          mem_type_o,
  output logic [MemIdW-1:0]                   mem_tid_o,
  input  logic                                mem_ack_i,
  input  logic                                mem_rtrn_vld_i,
  input  logic [RtrnWidth-1:0]                mem_rtrn_data_i,
  input  logic [2:0]                          mem_rtrn_type_i,
  input  logic [MemIdW-1:0]                   mem_rtrn_tid_i,
  input  logic                                mem_inv_req_i,
  input  logic [AddrWidth-1:0]                mem_inv_addr_i,
  output logic                                mem_inv_ack_o,
  output logic                                err_o
);
  localparam int CntW = $clog2(MaxOutstanding + 1);

  typedef enum logic [1:0] {INV_IDLE, INV_BCAST, INV_DONE} inv_state_e;

  inv_state_e                      inv_state_q, inv_state_d;
  logic [NumPorts-1:0]             pend_q, pend_d;
  logic [AddrWidth-1:0]            inv_addr_q, inv_addr_d;
  logic [NumPorts-1:0]             elig, avail, cnt_zero;
  logic [NumPorts-1:0][CntW-1:0]   cnt;
  logic [IdxW-1:0]                 win_idx, gnt_idx, gnt_q, gnt_d;
  logic                            win_vld, gnt_vld_q, gnt_vld_d, xfer;
  logic [IdxW-1:0]                 rtrn_idx;
  logic                            rtrn_idx_ok, err_q, err_d;

  // New grants are held off while an invalidation is in flight.
  assign elig = req_i & avail & {NumPorts{inv_state_q == INV_IDLE}};

`ifdef WT_MEM_ARB_FIXED_PRIO_EN
  // Fixed priority: lowest eligible index wins (scan high to low, last hit wins).
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    for (int i = NumPorts - 1; i >= 0; i--) begin
      if (elig[i]) begin
        win_vld = 1'b1;
        win_idx = IdxW'(i);
      end
    end
  end
`else
  logic [IdxW-1:0] ptr_q, ptr_d;
  logic [IdxW-1:0] cand;

  // Round-robin: first eligible port at or after the pointer, scanned so the
  // candidate closest to the pointer is written last.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int k = NumPorts - 1; k >= 0; k--) begin
      cand = IdxW'((int'(ptr_q) + k) % NumPorts);
      if (elig[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
  end

  // Pointer moves past the winner on every accepted transfer.
  always_comb begin
    ptr_d = ptr_q;
    if (xfer) ptr_d = (gnt_idx == IdxW'(NumPorts - 1)) ? '0 : gnt_idx + 1'b1;
  end

  // Round-robin pointer register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ptr_q <= '0;
    else         ptr_q <= ptr_d;
  end
`endif

  // A locked grant overrides arbitration until the memory side accepts it.
  assign gnt_idx   = gnt_vld_q ? gnt_q : win_idx;
  assign mem_req_o = gnt_vld_q | win_vld;
  assign xfer      = mem_req_o & mem_ack_i;

  // Lock the grant when a request is stalled, release on acceptance.
  always_comb begin
    gnt_vld_d = gnt_vld_q;
    gnt_d     = gnt_q;
    if (xfer) begin
      gnt_vld_d = 1'b0;
    end else if (mem_req_o) begin
      gnt_vld_d = 1'b1;
      gnt_d     = gnt_idx;
    end
  end

  // Granted payload, zeroed when nothing is requested.
  always_comb begin
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_type_o  = '0;
    mem_tid_o   = '0;
    if (mem_req_o) begin
      mem_addr_o  = req_addr_i[gnt_idx];
      mem_wdata_o = req_wdata_i[gnt_idx];
      mem_type_o  = req_type_i[gnt_idx];
      mem_tid_o   = {gnt_idx, req_tid_i[gnt_idx]};
    end
  end

  // Return routing: upper ID bits select the port, lower bits go back as-is.
  assign rtrn_idx    = mem_rtrn_tid_i[MemIdW-1 -: IdxW];
  assign rtrn_idx_ok = ({1'b0, rtrn_idx} < (IdxW + 1)'(NumPorts));
  assign rtrn_data_o = mem_rtrn_data_i;
  assign rtrn_type_o = mem_rtrn_type_i;
  assign rtrn_tid_o  = mem_rtrn_tid_i[TxIdWidth-1:0];

  for (genvar i = 0; i < NumPorts; i++) begin : g_port
    assign ack_o[i]      = xfer & (gnt_idx == IdxW'(i));
    assign rtrn_vld_o[i] = mem_rtrn_vld_i & rtrn_idx_ok & (rtrn_idx == IdxW'(i));
    assign cnt_zero[i]   = (cnt[i] == '0);

    // A stray return to an idle port is flagged but never underflows.
    wt_mem_arb_port_cnt #(
      .CntW           (CntW),
      .MaxOutstanding (MaxOutstanding)
    ) u_cnt (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .inc_i   (ack_o[i]),
      .dec_i   (rtrn_vld_o[i] & ~cnt_zero[i]),
      .cnt_o   (cnt[i]),
      .avail_o (avail[i])
    );
  end

  // Sticky error on out-of-range or unexpected returns.
  assign err_d = err_q | (mem_rtrn_vld_i & (~rtrn_idx_ok | (|(rtrn_vld_o & cnt_zero))));
  assign err_o = err_q;

  // Invalidation FSM: broadcast, collect per-port acks, single done pulse.
  always_comb begin
    inv_state_d   = inv_state_q;
    pend_d        = pend_q;
    inv_addr_d    = inv_addr_q;
    inv_req_o     = '0;
    mem_inv_ack_o = 1'b0;
    case (inv_state_q)
      INV_IDLE: begin
        if (mem_inv_req_i) begin
          inv_addr_d  = mem_inv_addr_i;
          pend_d      = '1;
          inv_state_d = INV_BCAST;
        end
      end
      INV_BCAST: begin
        inv_req_o = pend_q;
        pend_d    = pend_q & ~inv_ack_i;
        if (pend_d == '0) inv_state_d = INV_DONE;
      end
      INV_DONE: begin
        mem_inv_ack_o = 1'b1;
        inv_state_d   = INV_IDLE;
      end
      default: inv_state_d = INV_IDLE;
    endcase
  end

  assign inv_addr_o = inv_addr_q;

  // State registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      gnt_vld_q   <= 1'b0;
      gnt_q       <= '0;
      err_q       <= 1'b0;
      inv_state_q <= INV_IDLE;
      pend_q      <= '0;
      inv_addr_q  <= '0;
    end else begin
      gnt_vld_q   <= gnt_vld_d;
      gnt_q       <= gnt_d;
      err_q       <= err_d;
      inv_state_q <= inv_state_d;
      pend_q      <= pend_d;
      inv_addr_q  <= inv_addr_d;
    end
  end
endmodule

// File: tb/tb_wt_mem_arbiter.sv
// Self-checking bench for wt_mem_arbiter (NumPorts=3, MaxOutstanding=2).
`timescale 1ns/1ps
module tb_wt_mem_arbiter;
  localparam int NP = 3, AW = 56, DW = 64, RW = 128, TW = 2, MO = 2;
  localparam int IW = 2, MW = TW + IW;

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic [NP-1:0]             req_i;
  logic [NP-1:0][AW-1:0]     req_addr_i;
  logic [NP-1:0][DW-1:0]     req_wdata_i;
  logic [NP-1:0][2:0]        req_type_i;
  logic [NP-1:0][TW-1:0]     req_tid_i;
  logic [NP-1:0]             ack_o, rtrn_vld_o, inv_req_o, inv_ack_i;
  logic [RW-1:0]             rtrn_data_o, mem_rtrn_data_i;
  logic [2:0]                rtrn_type_o, mem_type_o, mem_rtrn_type_i;
  logic [TW-1:0]             rtrn_tid_o;
  logic [AW-1:0]             inv_addr_o, mem_addr_o, mem_inv_addr_i;
  logic                      mem_req_o, mem_ack_i, mem_rtrn_vld_i;
  logic                      mem_inv_req_i, mem_inv_ack_o, err_o;
  logic [DW-1:0]             mem_wdata_o;
  logic [MW-1:0]             mem_tid_o, mem_rtrn_tid_i;

  int n_pass = 0, n_tot = 0;
  int exp_q[$];
  int cnt_m[NP];

  wt_mem_arbiter #(
    .NumPorts(NP), .AddrWidth(AW), .DataWidth(DW), .RtrnWidth(RW),
    .TxIdWidth(TW), .MaxOutstanding(MO)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_i(req_i), .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
    .req_type_i(req_type_i), .req_tid_i(req_tid_i), .ack_o(ack_o),
    .rtrn_vld_o(rtrn_vld_o), .rtrn_data_o(rtrn_data_o), .rtrn_type_o(rtrn_type_o),
    .rtrn_tid_o(rtrn_tid_o), .inv_req_o(inv_req_o), .inv_addr_o(inv_addr_o),
    .inv_ack_i(inv_ack_i), .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_type_o(mem_type_o), .mem_tid_o(mem_tid_o),
    .mem_ack_i(mem_ack_i), .mem_rtrn_vld_i(mem_rtrn_vld_i),
    .mem_rtrn_data_i(mem_rtrn_data_i), .mem_rtrn_type_i(mem_rtrn_type_i),
    .mem_rtrn_tid_i(mem_rtrn_tid_i), .mem_inv_req_i(mem_inv_req_i),
    .mem_inv_addr_i(mem_inv_addr_i), .mem_inv_ack_o(mem_inv_ack_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic idle_in();
    req_i = '0; mem_ack_i = 1'b0; inv_ack_i = '0;
    mem_rtrn_vld_i = 1'b0; mem_rtrn_data_i = '0; mem_rtrn_type_i = '0; mem_rtrn_tid_i = '0;
    mem_inv_req_i = 1'b0; mem_inv_addr_i = '0;
    for (int i = 0; i < NP; i++) begin
      req_addr_i[i]  = AW'(64'h1000 + i);
      req_wdata_i[i] = DW'(64'hD000 + i);
      req_type_i[i]  = 3'(i + 1);
      req_tid_i[i]   = TW'(i + 1);
    end
  endtask

  // Return every outstanding request; each return checked via the scoreboard.
  task automatic drain();
    for (int p = 0; p < NP; p++) begin
      while (cnt_m[p] > 0) begin
        @(negedge clk);
        mem_rtrn_vld_i  = 1'b1;
        mem_rtrn_tid_i  = {IW'(p), TW'(p)};
        mem_rtrn_data_i = {4{32'hC0DE0000 + 32'(p)}};
        exp_q.push_back(1 << p);
        #1;
        begin
          int e;
          e = exp_q.pop_front();
          n_tot++;
          if (rtrn_vld_o !== NP'(e) || rtrn_tid_o !== TW'(p) ||
              rtrn_data_o !== {4{32'hC0DE0000 + 32'(p)}})
            $display("FAIL drain_rtrn: got vld=%b tid=%0d data=%h want vld=%b tid=%0d",
                     rtrn_vld_o, rtrn_tid_o, rtrn_data_o, NP'(e), p);
          else n_pass++;
        end
        cnt_m[p]--;
      end
    end
    @(negedge clk); mem_rtrn_vld_i = 1'b0; #1;
    n_tot++;
    if (err_o !== 1'b0) $display("FAIL drain_err: got %b want 0", err_o); else n_pass++;
  endtask

  task automatic test_reset();
    idle_in();
    rst_n = 1'b0;
    @(negedge clk); #1;
    n_tot++;
    if ({mem_req_o, ack_o, rtrn_vld_o, inv_req_o} !== '0)
      $display("FAIL reset_req: got req=%b ack=%b rv=%b inv=%b want 0", mem_req_o, ack_o, rtrn_vld_o, inv_req_o);
    else n_pass++;
    n_tot++;
    if ({mem_inv_ack_o, err_o} !== 2'b00 || inv_addr_o !== '0 || mem_tid_o !== '0)
      $display("FAIL reset_misc: got iack=%b err=%b iaddr=%h tid=%h want 0", mem_inv_ack_o, err_o, inv_addr_o, mem_tid_o);
    else n_pass++;
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_round_robin();
    for (int k = 0; k < 6; k++) exp_q.push_back(k % NP);
    @(negedge clk); req_i = '1; mem_ack_i = 1'b1;
    for (int c = 0; c < 12 && exp_q.size() > 0; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      if (mem_req_o) begin
        int e;
        e = exp_q.pop_front();
        cnt_m[e]++;
        n_tot++;
        if (mem_tid_o !== {IW'(e), TW'(e + 1)} || mem_addr_o !== AW'(64'h1000 + e) ||
            mem_wdata_o !== DW'(64'hD000 + e) || ack_o !== NP'(1 << e))
          $display("FAIL rr_grant: got tid=%h addr=%h ack=%b want port %0d", mem_tid_o, mem_addr_o, ack_o, e);
        else n_pass++;
      end
    end
    n_tot++;
    if (exp_q.size() != 0) begin
      $display("FAIL rr_timeout: got %0d grants pending want 0", exp_q.size());
      exp_q.delete();
    end else n_pass++;
    // every port now holds MaxOutstanding requests
    @(negedge clk); #1;
    n_tot++;
    if (mem_req_o !== 1'b0) $display("FAIL rr_saturate: got mem_req=%b want 0", mem_req_o); else n_pass++;
    mem_ack_i = 1'b0; req_i = '0;
  endtask

  task automatic test_outstanding();
    @(negedge clk); req_i = 3'b001; #1;
    n_tot++;
    if (mem_req_o !== 1'b0) $display("FAIL out_masked: got mem_req=%b want 0", mem_req_o); else n_pass++;
    @(negedge clk);
    mem_rtrn_vld_i = 1'b1; mem_rtrn_tid_i = {IW'(0), TW'(3)}; mem_rtrn_data_i = {4{32'hA5A5_0F0F}};
    exp_q.push_back(1);
    #1;
    begin
      int e;
      e = exp_q.pop_front();
      n_tot++;
      if (rtrn_vld_o !== NP'(e) || rtrn_tid_o !== 2'd3 || mem_req_o !== 1'b0)
        $display("FAIL out_rtrn: got vld=%b tid=%0d req=%b want vld=%b tid=3 req=0", rtrn_vld_o, rtrn_tid_o, mem_req_o, NP'(e));
      else n_pass++;
    end
    cnt_m[0]--;
    @(negedge clk); mem_rtrn_vld_i = 1'b0; mem_ack_i = 1'b1; #1;
    n_tot++;
    if (mem_req_o !== 1'b1 || mem_tid_o[MW-1 -: IW] !== 2'd0 || ack_o !== 3'b001)
      $display("FAIL out_regrant: got req=%b port=%0d ack=%b want 1/0/001", mem_req_o, mem_tid_o[MW-1 -: IW], ack_o);
    else n_pass++;
    cnt_m[0]++;
    @(negedge clk); mem_ack_i = 1'b0; req_i = '0;
    drain();
  endtask

  task automatic test_grant_lock();
    logic [AW-1:0] a1;
    a1 = AW'(64'h0ABC_0001);
    @(negedge clk); req_i = 3'b010; req_addr_i[1] = a1;
    for (int s = 0; s < 5; s++) begin
      if (s > 0) @(negedge clk);
      if (s == 1) req_i[0] = 1'b1;
      #1;
      n_tot++;
      if (mem_req_o !== 1'b1 || mem_tid_o[MW-1 -: IW] !== 2'd1 || mem_addr_o !== a1 || ack_o !== '0)
        $display("FAIL lock_stall: got req=%b port=%0d addr=%h ack=%b want 1/1/%h/000",
                 mem_req_o, mem_tid_o[MW-1 -: IW], mem_addr_o, ack_o, a1);
      else n_pass++;
    end
    @(negedge clk); mem_ack_i = 1'b1; #1;
    n_tot++;
    if (ack_o !== 3'b010) $display("FAIL lock_ack1: got %b want 010", ack_o); else n_pass++;
    cnt_m[1]++;
    @(negedge clk); req_i[1] = 1'b0; #1;
    n_tot++;
    if (mem_req_o !== 1'b1 || mem_tid_o[MW-1 -: IW] !== 2'd0 || ack_o !== 3'b001)
      $display("FAIL lock_next: got req=%b port=%0d ack=%b want 1/0/001", mem_req_o, mem_tid_o[MW-1 -: IW], ack_o);
    else n_pass++;
    cnt_m[0]++;
    @(negedge clk); mem_ack_i = 1'b0; req_i = '0; req_addr_i[1] = AW'(64'h1001);
    drain();
  endtask

  task automatic test_invalidation();
    int pulses;
    pulses = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      mem_inv_req_i  = (c <= 6);
      mem_inv_addr_i = AW'(64'h8000_1040);
      req_i          = (c >= 1) ? 3'b100 : 3'b000;
      inv_ack_i      = (c == 2) ? 3'b001 : (c == 5) ? 3'b110 : 3'b000;
      #1;
      if (mem_inv_ack_o) pulses++;
      if (c == 1) begin
        n_tot++;
        if (inv_req_o !== 3'b111 || inv_addr_o !== AW'(64'h8000_1040))
          $display("FAIL inv_bcast: got req=%b addr=%h want 111/80001040", inv_req_o, inv_addr_o);
        else n_pass++;
      end
      if (c == 3) begin
        n_tot++;
        if (inv_req_o !== 3'b110) $display("FAIL inv_pend: got %b want 110", inv_req_o); else n_pass++;
      end
      n_tot++;
      if (mem_inv_ack_o !== (c == 6))
        $display("FAIL inv_ack_c%0d: got %b want %b", c, mem_inv_ack_o, (c == 6));
      else n_pass++;
      n_tot++;
      if (mem_req_o !== (c >= 7))
        $display("FAIL inv_block_c%0d: got mem_req=%b want %b", c, mem_req_o, (c >= 7));
      else n_pass++;
    end
    n_tot++;
    if (pulses != 1) $display("FAIL inv_pulses: got %0d want 1", pulses); else n_pass++;
    @(negedge clk); mem_ack_i = 1'b1; #1;
    n_tot++;
    if (ack_o !== 3'b100) $display("FAIL inv_grant: got %b want 100", ack_o); else n_pass++;
    cnt_m[2]++;
    @(negedge clk); mem_ack_i = 1'b0; req_i = '0;
    drain();
  endtask

  task automatic test_bad_return();
    @(negedge clk); mem_rtrn_vld_i = 1'b1; mem_rtrn_tid_i = {2'd3, 2'd0}; #1;
    n_tot++;
    if (rtrn_vld_o !== '0 || err_o !== 1'b0)
      $display("FAIL bad_route: got vld=%b err=%b want 000/0", rtrn_vld_o, err_o);
    else n_pass++;
    @(negedge clk); mem_rtrn_vld_i = 1'b0; #1;
    n_tot++;
    if (err_o !== 1'b1) $display("FAIL bad_err: got %b want 1", err_o); else n_pass++;
    repeat (3) @(negedge clk);
    #1;
    n_tot++;
    if (err_o !== 1'b1) $display("FAIL bad_sticky: got %b want 1", err_o); else n_pass++;
    rst_n = 1'b0; #1;
    n_tot++;
    if (err_o !== 1'b0) $display("FAIL bad_clear: got %b want 0", err_o); else n_pass++;
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_prio();
`ifdef WT_MEM_ARB_FIXED_PRIO_EN
    exp_q.push_back(0); exp_q.push_back(0);
`else
    exp_q.push_back(0); exp_q.push_back(2);
`endif
    @(negedge clk); req_i = 3'b101; mem_ack_i = 1'b1;
    for (int c = 0; c < 6 && exp_q.size() > 0; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      if (mem_req_o) begin
        int e;
        e = exp_q.pop_front();
        cnt_m[e]++;
        n_tot++;
        if (mem_tid_o[MW-1 -: IW] !== IW'(e) || ack_o !== NP'(1 << e))
          $display("FAIL prio_grant: got port=%0d ack=%b want port %0d", mem_tid_o[MW-1 -: IW], ack_o, e);
        else n_pass++;
      end
    end
    n_tot++;
    if (exp_q.size() != 0) begin
      $display("FAIL prio_timeout: got %0d grants pending want 0", exp_q.size());
      exp_q.delete();
    end else n_pass++;
    @(negedge clk); mem_ack_i = 1'b0; req_i = '0;
    drain();
  endtask

  initial begin
    for (int i = 0; i < NP; i++) cnt_m[i] = 0;
    rst_n = 1'b0;
    idle_in();
    test_reset();
    test_round_robin();
    test_outstanding();
    test_grant_lock();
    test_invalidation();
    test_bad_return();
    test_prio();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
